mem_responder: RTL and testbench
================================

# mem_responder

Main-memory responder that sits on the far side of the cache arbiter's memory port. It accepts one 128-bit line request at a time over the `is_mem_req` / `mem_ready` handshake and performs the read or write against an internal line array. It returns read data with a one-cycle `mem_ready` pulse after a fixed, parameterised latency. It serves as the on-chip backing store for iCache/dCache refills and dCache write-backs.

## Interface

Parameters:
- `DEPTH_LOG2`, default 8: log2 of the number of 128-bit lines stored (default 256 lines, 4 KiB).
- `LATENCY`, default 4: cycles from request capture to `mem_ready`; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `is_mem_req`  in  1  request valid from the arbiter; held high until `mem_ready`.
- `mem_addr`  in  20  byte address of the line; bits [3:0] are ignored.
- `mem_we`  in  1  1 = write line, 0 = read line; sampled at capture.
- `dcache_to_mem_data_out`  in  128  write data; sampled at capture.
- `data_from_mem`  out  128  response line.
- `mem_ready`  out  1  one-cycle response strobe.
- `mem_error`  out  1  out-of-range strobe, coincident with `mem_ready`. Tied to 0 unless `MEM_RESP_BOUNDS_EN` is defined.

## Operation

- Line index is `mem_addr[4+DEPTH_LOG2-1:4]`. Array contents are not reset.
- State machine has four states: IDLE, BUSY, RESP, DONE. Reset (`reset`=0) forces IDLE with the counter at 0 and all outputs at 0 (`data_from_mem`=0, `mem_ready`=0, `mem_error`=0).
- IDLE: when `is_mem_req`=1, capture address, we and write data, load the counter with LATENCY-1, and go to BUSY.
- BUSY:
  - If `is_mem_req`=0, abort and go to IDLE. There is no array write and no `mem_ready`. This covers the arbiter's `reset_mem_req`.
  - Otherwise, if the counter is 0, go to RESP.
  - Otherwise, decrement the counter.
- On entry to RESP:
  - A write commits the captured data to the array.
  - `data_from_mem` loads the stored line for a read, or the written line for a write.
  - `mem_ready` is set to 1.
- RESP lasts exactly one cycle and `mem_ready` returns to 0 on the next edge. The next state is IDLE if `is_mem_req`=0, otherwise DONE.
- DONE: wait for `is_mem_req`=0, then go to IDLE. A request still held after the response is never served twice.
- `data_from_mem` holds its value until the next RESP.
- Address and data changes after capture are ignored.
- A request arriving on the same edge that RESP or DONE exits to IDLE is not captured until the following IDLE edge.

## Timing

- A request captured at edge P0 produces `mem_ready`=1 in the cycle following edge P0+LATENCY.
- Turnaround: the arbiter drops `is_mem_req` during the RESP cycle, so the block is in IDLE one edge after RESP. The earliest back-to-back capture is therefore LATENCY+2 edges after the previous capture.
- Asynchronous reset mid-transaction discards the request immediately. Any pending write is lost and `mem_ready` never pulses.

## Configuration

- `MEM_RESP_BOUNDS_EN` defined:
  - A captured address with any nonzero bit in [19:4+DEPTH_LOG2] is out of range.
  - At RESP it pulses `mem_error`=1 together with `mem_ready`=1, suppresses the write, and returns `data_from_mem`=0.
- Not defined: upper address bits are ignored, so addresses alias modulo the array size, and `mem_error` is constant 0.

## Test plan

- Reset: hold `reset`=0 with random inputs -> `mem_ready`=0, `data_from_mem`=0, `mem_error`=0; a request at the first edge after release is captured.
- Write then read, LATENCY=4: write 128'hDEAD…BEEF to 20'h00120 captured at P0 -> `mem_ready` pulses for exactly 1 cycle after P4. A read of 20'h0012C then returns 128'hDEAD…BEEF, since bits [3:0] are ignored.
- LATENCY=1: read captured at P0 -> `mem_ready` high in the cycle after P1, and the next capture succeeds at P3.
- Abort: drop `is_mem_req` during BUSY on a write to 20'h00040 -> no `mem_ready`. A later read of 20'h00040 returns the old contents.
- Held request: keep `is_mem_req`=1 for 10 cycles after the response -> exactly one `mem_ready` pulse; the block stays in DONE until the request drops.
- Bounds, DEPTH_LOG2=8:
  - Macro defined: a write to 20'h10000 -> `mem_ready`=`mem_error`=1, `data_from_mem`=0, and line 0 is unchanged.
  - Macro undefined: the same write updates line 0 and `mem_error` stays 0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: 128-bit line backing store behind the arbiter memory port.
// Optional MEM_RESP_BOUNDS_EN flags out-of-range line addresses via mem_error.
module mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_mem_req,
    input  logic [19:0]  mem_addr,
    input  logic         mem_we,
    input  logic [127:0] dcache_to_mem_data_out,
    output logic [127:0] data_from_mem,
    output logic         mem_ready,
    output logic         mem_error
);

    localparam int LINES = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  we_q;
    logic                  oob_q;
    logic                  err_q;
    logic [127:0]          wdata_q;
    logic [127:0]          lines [LINES];
    logic                  capture;
    logic                  enter_resp;
    logic                  out_of_range;
    logic                  unused_addr;

    // Offset bits never select anything; upper bits only matter with bounds.
    assign unused_addr = ^mem_addr;

`ifdef MEM_RESP_BOUNDS_EN
    assign out_of_range = (mem_addr >> (4 + DEPTH_LOG2)) != 20'd0;
`else
    assign out_of_range = 1'b0;
`endif

    assign capture    = (state == IDLE) && is_mem_req;
    assign enter_resp = (state == BUSY) && is_mem_req && (cnt == 4'd0);
    assign mem_error  = err_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: dropping the request in BUSY aborts without a response.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (is_mem_req) state_nxt = BUSY;
            BUSY: begin
                if (!is_mem_req) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = is_mem_req ? DONE : IDLE;
            DONE: if (!is_mem_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, latency countdown and the registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= 4'd0;
            idx_q         <= '0;
            we_q          <= 1'b0;
            oob_q         <= 1'b0;
            wdata_q       <= '0;
            data_from_mem <= '0;
            mem_ready     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            err_q     <= 1'b0;
            if (capture) begin
                idx_q   <= mem_addr[4+DEPTH_LOG2-1:4];
                we_q    <= mem_we;
                oob_q   <= out_of_range;
                wdata_q <= dcache_to_mem_data_out;
                cnt     <= 4'(LATENCY - 1);
            end else if ((state == BUSY) && is_mem_req && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                mem_ready <= 1'b1;
                err_q     <= oob_q;
                if (oob_q) begin
                    data_from_mem <= '0;
                end else if (we_q) begin
                    data_from_mem <= wdata_q;
                end else begin
                    data_from_mem <= lines[idx_q];
                end
            end
        end
    end

    // Line array commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && we_q && !oob_q) begin
            lines[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (LATENCY 4 and 1) on shared stimulus,
// checked every cycle against a transaction-level model plus literal pins.
module tb_mem_responder;

    localparam int DL = 8;
    localparam int NL = 1 << DL;
    localparam logic [127:0] PAT = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] VA  = 128'hAAAA_0001_0002_0003_0004_0005_0006_0007;
    localparam logic [127:0] VB  = 128'hBBBB_1000_2000_3000_4000_5000_6000_7000;
    localparam logic [127:0] VC  = 128'hCCCC_CCCC_0000_1234_5678_9ABC_DEF0_CCCC;
    localparam logic [127:0] VZ  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req = 1'b0;
    logic [19:0]  addr = '0;
    logic         we = 1'b0;
    logic [127:0] wd = '0;
    logic [127:0] d4, d1;
    logic         r4, r1, e4, e1;

    int checks = 0;
    int errors = 0;

    mem_responder #(.DEPTH_LOG2(DL), .LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .is_mem_req(req), .mem_addr(addr),
        .mem_we(we), .dcache_to_mem_data_out(wd),
        .data_from_mem(d4), .mem_ready(r4), .mem_error(e4)
    );

    mem_responder #(.DEPTH_LOG2(DL), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .is_mem_req(req), .mem_addr(addr),
        .mem_we(we), .dcache_to_mem_data_out(wd),
        .data_from_mem(d1), .mem_ready(r1), .mem_error(e1)
    );

    always #5 clk = ~clk;

    // Model state per DUT: 0 -> LATENCY 4, 1 -> LATENCY 1.
    int           lat [2] = '{4, 1};
    bit           m_act [2];
    bit           m_srv [2];
    int           m_age [2];
    logic [19:0]  m_addr [2];
    bit           m_we [2];
    logic [127:0] m_wd [2];
    logic [127:0] m_mem [2][NL];
    bit           m_known [2][NL];
    bit           exp_rdy [2];
    bit           exp_err [2];
    logic [127:0] exp_d [2];
    bit           exp_dk [2];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [19:0] rnd_addr();
        logic [19:0] a;
        int          i;
        i = $urandom_range(0, 7);
        a = '0;
        a[11:4] = (i == 7) ? 8'h12 : 8'(i);
        a[3:0] = 4'($urandom);
        if ($urandom_range(0, 3) == 0) a[19:12] = 8'($urandom);
        return a;
    endfunction

    function automatic bit is_oob(input logic [19:0] a);
`ifdef MEM_RESP_BOUNDS_EN
        return (a >> (4 + DL)) != 20'd0;
`else
        return 1'b0 | (a == 20'hFFFFF && 1'b0);
`endif
    endfunction

    // A captured request is served LATENCY edges later if never dropped;
    // after a response the block frees at the first edge with req low.
    task automatic step(input int k);
        int idx;
        exp_rdy[k] = 1'b0;
        exp_err[k] = 1'b0;
        if (!m_act[k]) begin
            if (req) begin
                m_act[k] = 1'b1;
                m_srv[k] = 1'b0;
                m_age[k] = 0;
                m_addr[k] = addr;
                m_we[k] = we;
                m_wd[k] = wd;
            end
        end else if (!m_srv[k]) begin
            if (!req) begin
                m_act[k] = 1'b0;
            end else begin
                m_age[k]++;
                if (m_age[k] == lat[k]) begin
                    m_srv[k] = 1'b1;
                    idx = int'(m_addr[k][DL+3:4]);
                    exp_rdy[k] = 1'b1;
                    exp_dk[k] = 1'b1;
                    if (is_oob(m_addr[k])) begin
                        exp_err[k] = 1'b1;
                        exp_d[k] = '0;
                    end else if (m_we[k]) begin
                        m_mem[k][idx] = m_wd[k];
                        m_known[k][idx] = 1'b1;
                        exp_d[k] = m_wd[k];
                    end else begin
                        exp_d[k] = m_mem[k][idx];
                        exp_dk[k] = m_known[k][idx];
                    end
                end
            end
        end else if (!req) begin
            m_act[k] = 1'b0;
        end
    endtask

    // Reference model advance.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 1'b0;
                m_srv[k] = 1'b0;
                exp_rdy[k] = 1'b0;
                exp_err[k] = 1'b0;
                exp_d[k] = '0;
                exp_dk[k] = 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) step(k);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ready_l4", 128'(r4), 128'(exp_rdy[0]));
        chk("error_l4", 128'(e4), 128'(exp_err[0]));
        if (exp_dk[0]) chk("data_l4", d4, exp_d[0]);
        chk("ready_l1", 128'(r1), 128'(exp_rdy[1]));
        chk("error_l1", 128'(e1), 128'(exp_err[1]));
        if (exp_dk[1]) chk("data_l1", d1, exp_d[1]);
    end

    // One transaction paced by the LATENCY-4 responder.
    task automatic xact4(input logic [19:0] a, input logic w,
                         input logic [127:0] d, input int hold,
                         output int n, output int pulses,
                         output logic [127:0] dq, output logic eq);
        req = 1'b1;
        addr = a;
        we = w;
        wd = d;
        n = 0;
        pulses = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                addr = rnd_addr();
                wd = rnd128();
                we = ~w;
            end
        end while (!r4 && n < 40);
        if (!r4) begin
            checks++;
            errors++;
            $display("FAIL timeout got no ready want ready");
        end else begin
            pulses = 1;
        end
        dq = d4;
        eq = e4;
        repeat (hold) begin
            @(negedge clk);
            if (r4) pulses++;
        end
        req = 1'b0;
        @(negedge clk);
        if (r4) pulses++;
        @(negedge clk);
    endtask

    initial begin
        int           n, p;
        logic [127:0] dq;
        logic         eq;

        // Reset held with random inputs.
        repeat (4) begin
            req = 1'($urandom);
            addr = rnd_addr();
            we = 1'($urandom);
            wd = rnd128();
            @(negedge clk);
        end
        chk("rst_ready", 128'(r4), 128'd0);
        chk("rst_data", d4, 128'd0);
        chk("rst_error", 128'(e4), 128'd0);
        chk("rst_data_l1", d1, 128'd0);

        // Write then read with offset bits ignored.
        reset = 1'b1;
        xact4(20'h00120, 1'b1, PAT, 0, n, p, dq, eq);
        chk("lat_write", 128'(n), 128'd5);
        chk("pulses_write", 128'(p), 128'd1);
        chk("wdata_echo", dq, PAT);
        xact4(20'h0012C, 1'b0, 128'd0, 0, n, p, dq, eq);
        chk("read_back", dq, PAT);

        // Abort right after capture leaves old contents.
        xact4(20'h00040, 1'b1, VA, 0, n, p, dq, eq);
        req = 1'b1;
        addr = 20'h00040;
        we = 1'b1;
        wd = VB;
        @(negedge clk);
        req = 1'b0;
        p = 0;
        repeat (6) begin
            @(negedge clk);
            if (r4 || r1) p++;
        end
        chk("abort_pulses", 128'(p), 128'd0);
        xact4(20'h00040, 1'b0, 128'd0, 0, n, p, dq, eq);
        chk("abort_old", dq, VA);

        // LATENCY 1 back-to-back turnaround.
        req = 1'b1;
        addr = 20'h00120;
        we = 1'b0;
        @(negedge clk);
        chk("l1_p0", 128'(r1), 128'd0);
        @(negedge clk);
        chk("l1_resp", 128'(r1), 128'd1);
        chk("l1_data", d1, PAT);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        addr = 20'h00040;
        @(negedge clk);
        chk("l1_cap", 128'(r1), 128'd0);
        @(negedge clk);
        chk("l1_b2b", 128'(r1), 128'd1);
        chk("l1_data2", d1, VA);
        req = 1'b0;
        repeat (2) @(negedge clk);

        // Held request is served once.
        xact4(20'h00120, 1'b0, 128'd0, 10, n, p, dq, eq);
        chk("held_pulses", 128'(p), 128'd1);

        // Bounds / aliasing on line 0.
        xact4(20'h00000, 1'b1, VZ, 0, n, p, dq, eq);
        xact4(20'h10000, 1'b1, VC, 0, n, p, dq, eq);
`ifdef MEM_RESP_BOUNDS_EN
        chk("oob_error", 128'(eq), 128'd1);
        chk("oob_data", dq, 128'd0);
        xact4(20'h00000, 1'b0, 128'd0, 0, n, p, dq, eq);
        chk("oob_line0", dq, VZ);
`else
        chk("alias_error", 128'(eq), 128'd0);
        chk("alias_data", dq, VC);
        xact4(20'h00000, 1'b0, 128'd0, 0, n, p, dq, eq);
        chk("alias_line0", dq, VC);
`endif

        // Asynchronous reset mid-write discards it.
        xact4(20'h00050, 1'b1, VA, 0, n, p, dq, eq);
        req = 1'b1;
        addr = 20'h00050;
        we = 1'b1;
        wd = VB;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 128'(r4), 128'd0);
        chk("midrst_data", d4, 128'd0);
        reset = 1'b1;
        req = 1'b0;
        p = 0;
        repeat (6) begin
            @(negedge clk);
            if (r4) p++;
        end
        chk("midrst_pulses", 128'(p), 128'd0);
        xact4(20'h00050, 1'b0, 128'd0, 0, n, p, dq, eq);
        chk("midrst_old", dq, VA);

        // Randomized request traffic.
        for (int t = 0; t < 250; t++) begin
            req = 1'b1;
            addr = rnd_addr();
            we = 1'($urandom);
            wd = rnd128();
            repeat ($urandom_range(1, 9)) begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    addr = rnd_addr();
                    we = 1'($urandom);
                    wd = rnd128();
                end
            end
            req = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
